// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the accumulator datapath and alu_mc.
// Latency: none, signal grouping only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;

    // Issuing side: the control FSM / operand path
    modport master (
        output in_valid, opcode, inA, inB, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal
    );

    // The ALU itself
    modport slave (
        input  in_valid, opcode, inA, inB, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with flags: single-cycle logic/arith/shift ops, iterative shift-add MUL.
// Latency: result valid the cycle after accept; MUL result valid WIDTH+1 cycles after accept.
// Backpressure: result held stable in DONE until out_ready; in_ready follows out_ready in DONE for back-to-back issue.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_mc_if.slave bus
);
    // Shift-amount width is tied to WIDTH and not meant to be overridden
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_PASSB = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;          // multiplicand captured at accept
    logic [2*WIDTH-1:0]   prod_q, prod_d;    // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 ill_q, ill_d;

    logic                 in_ready;
    logic                 accept;

    // Single-cycle datapath outputs
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_ill;
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [WIDTH:0]       shl_w;
    logic [WIDTH:0]       shr_w;
    logic signed [WIDTH:0] sra_w;

    // Multiply step
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;

    // Single-cycle ops, evaluated on the live operands so they can be registered at the accept edge
    always_comb begin
        shamt   = bus.inB[SHW-1:0];
        add_w   = {1'b0, bus.inA} + {1'b0, bus.inB};
        sub_w   = {1'b0, bus.inA} - {1'b0, bus.inB};
        // One guard bit on the outgoing side of each shift catches the last bit shifted out (0 for n=0)
        shl_w   = {1'b0, bus.inA} << shamt;
        shr_w   = {bus.inA, 1'b0} >> shamt;
        sra_w   = $signed({bus.inA, 1'b0}) >>> shamt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (bus.opcode)
            OP_PASSA: alu_res = bus.inA;
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (bus.inA[WIDTH-1] == bus.inB[WIDTH-1]) &&
                          (add_w[WIDTH-1] != bus.inA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];   // borrow: A < B unsigned
                alu_v   = (bus.inA[WIDTH-1] != bus.inB[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != bus.inA[WIDTH-1]);
            end
            OP_AND:   alu_res = bus.inA & bus.inB;
            OP_OR:    alu_res = bus.inA | bus.inB;
            OP_XOR:   alu_res = bus.inA ^ bus.inB;
            OP_PASSB: alu_res = bus.inB;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            OP_MUL:   alu_res = '0;       // handled by the iterative path
            default:  alu_ill = 1'b1;
        endcase
    end

    // One shift-add iteration: add multiplicand into the upper half if the current multiplier bit is set, then shift right
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // Next-state and register-update logic for the control FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        prod_d   = prod_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;

        case (state_q)
            BUSY: begin
                prod_d = mul_next;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = mul_next[WIDTH-1:0];
                    zero_d   = (mul_next[WIDTH-1:0] == '0);
                    neg_d    = mul_next[WIDTH-1];
                    carry_d  = |mul_next[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept overrides the above; only possible from IDLE or from DONE with out_ready
        if (accept) begin
            if (bus.opcode == OP_MUL) begin
                state_d = BUSY;
                cnt_d   = SHW'(WIDTH - 1);
                a_d     = bus.inA;
                prod_d  = {{WIDTH{1'b0}}, bus.inB};
            end else begin
                state_d  = DONE;
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                neg_d    = alu_res[WIDTH-1];
                carry_d  = alu_c;
                ovf_d    = alu_v;
                ill_d    = alu_ill;
            end
        end
    end

    // State, datapath and flag registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_alu_mc;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_mc_if #(.WIDTH(8)) bus ();

    alu_mc #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one edge; on return we sit in the cycle after the accept edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.inA      = a;
        bus.inB      = b;
        step();
        bus.in_valid = 1'b0;
        bus.inA      = 8'h00;
        bus.inB      = 8'h00;
        bus.opcode   = 4'd0;
    endtask

    // flags packed as {zero, negative, carry, overflow, illegal}
    function automatic logic [4:0] flags();
        return {bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal};
    endfunction

    initial begin
        logic stale;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.inA       = 8'h00;
        bus.inB       = 8'h00;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready",  16'(bus.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_result",    16'(bus.result), 16'h00);
        chk("rst_flags",     16'(flags()), 16'b00000);
        #3 rst_n = 1'b1;
        step();

        // ADD wraps to zero with carry out
        issue(4'd1, 8'hFF, 8'h01);
        chk("add_ff_valid",  16'(bus.out_valid), 16'd1);
        chk("add_ff_result", 16'(bus.result), 16'h00);
        chk("add_ff_flags",  16'(flags()), 16'b10100);

        // ADD signed overflow
        issue(4'd1, 8'h7F, 8'h01);
        chk("add_7f_result", 16'(bus.result), 16'h80);
        chk("add_7f_flags",  16'(flags()), 16'b01010);

        // SUB signed overflow, no borrow
        issue(4'd2, 8'h80, 8'h01);
        chk("sub_80_result", 16'(bus.result), 16'h7F);
        chk("sub_80_flags",  16'(flags()), 16'b00010);

        // SUB borrow
        issue(4'd2, 8'h00, 8'h01);
        chk("sub_00_result", 16'(bus.result), 16'hFF);
        chk("sub_00_flags",  16'(flags()), 16'b01100);

        // Logic and pass ops
        issue(4'd3, 8'hF0, 8'h3C);
        chk("and_result", 16'(bus.result), 16'h30);
        issue(4'd4, 8'hF0, 8'h0F);
        chk("or_result",  16'(bus.result), 16'hFF);
        chk("or_flags",   16'(flags()), 16'b01000);
        issue(4'd6, 8'h12, 8'h5A);
        chk("passb_result", 16'(bus.result), 16'h5A);

        // Shifts: carry is last bit out, 0 when amount is 0; upper inB bits ignored
        issue(4'd7, 8'h81, 8'h01);
        chk("shl1_result", 16'(bus.result), 16'h02);
        chk("shl1_carry",  16'(bus.carry), 16'd1);
        issue(4'd7, 8'h81, 8'h08);
        chk("shl0_result", 16'(bus.result), 16'h81);
        chk("shl0_carry",  16'(bus.carry), 16'd0);
        issue(4'd8, 8'h0F, 8'h04);
        chk("shr4_result", 16'(bus.result), 16'h00);
        chk("shr4_flags",  16'(flags()), 16'b10100);

        // MUL 0x0F*0x11: 8 busy cycles, result on the 9th
        issue(4'd10, 8'h0F, 8'h11);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul_busy_c%0d", i + 1), 16'({bus.in_ready, bus.out_valid}), 16'b00);
            step();
        end
        chk("mul_ff_valid",  16'(bus.out_valid), 16'd1);
        chk("mul_ff_result", 16'(bus.result), 16'hFF);
        chk("mul_ff_flags",  16'(flags()), 16'b01000);

        // MUL with product overflowing into the high half
        issue(4'd10, 8'h10, 8'h10);
        for (int i = 0; i < 8; i++) step();
        chk("mul_100_valid",  16'(bus.out_valid), 16'd1);
        chk("mul_100_result", 16'(bus.result), 16'h00);
        chk("mul_100_flags",  16'(flags()), 16'b10100);

        // Back to IDLE, then XOR held under backpressure
        step();
        chk("idle_out_valid", 16'(bus.out_valid), 16'd0);
        bus.out_ready = 1'b0;
        issue(4'd5, 8'hA5, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_c%0d", i + 1),
                16'({bus.out_valid, bus.in_ready, bus.result}), 16'({2'b10, 8'h5A}));
            if (i < 2) step();
        end

        // Release with a new op waiting: pass-through accept on the same edge
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'd9;
        bus.inA       = 8'h90;
        bus.inB       = 8'h03;
        #1;
        chk("bp_pass_in_ready", 16'(bus.in_ready), 16'd1);
        step();
        bus.in_valid = 1'b0;
        chk("sra_valid",  16'(bus.out_valid), 16'd1);
        chk("sra_result", 16'(bus.result), 16'hF2);
        chk("sra_flags",  16'(flags()), 16'b01000);

        // Illegal opcode then recovery
        issue(4'd12, 8'h33, 8'h00);
        chk("ill_result", 16'(bus.result), 16'h00);
        chk("ill_flags",  16'(flags()), 16'b10001);
        issue(4'd0, 8'h33, 8'h00);
        chk("passa_result", 16'(bus.result), 16'h33);
        chk("passa_flags",  16'(flags()), 16'b00000);

        // Reset four cycles into a MUL
        step();
        issue(4'd10, 8'h0F, 8'h11);
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("arst_in_ready",  16'(bus.in_ready), 16'd1);
        chk("arst_result",    16'(bus.result), 16'h00);
        step();
        step();
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        chk("arst_no_stale", 16'(stale), 16'd0);

        // Normal operation after reset
        issue(4'd6, 8'h00, 8'hC3);
        chk("post_rst_result", 16'(bus.result), 16'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle ALU. Next generation of the accumulator-datapath ALU for the RISC CPU.
- Generalises width and adds SUB, OR, shifts and an iterative multiply.
- Adds a full flag set and valid/ready handshakes on both input and output, so the control FSM can stall on slow ops.
- Sits between the accumulator/memory operand path and the accumulator write-back.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept an operation this cycle.
- opcode  input  4  operation select.
- inA  input  WIDTH  operand A (accumulator).
- inB  input  WIDTH  operand B (memory); for shifts, inB[SHW-1:0] is the amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- carry  output  1  carry/borrow/shift-out/mul-overflow (per op).
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- illegal  output  1  opcode 11..15 was issued.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0. All flags 0, except zero=0 (flags are registered, not derived live). Internal counter and partial product cleared.
- Accept condition: a rising edge with in_valid && in_ready. inA, inB and opcode are captured at that edge and are not required to be held afterwards.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL only; in_ready=0, out_valid=0.
  - DONE: out_valid=1. in_ready = out_ready, which gives pass-through issue.
- Transitions:
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of MUL.
  - BUSY -> DONE after WIDTH BUSY cycles (counter WIDTH-1 down to 0).
  - DONE with out_ready && in_valid: accept a new op the same edge. Go to DONE (single-cycle) or BUSY (MUL).
  - DONE with out_ready && !in_valid: -> IDLE.
  - DONE with !out_ready: hold. result and flags must stay stable.
- Latency:
  - Single-cycle ops: out_valid is visible in the cycle after the accept edge.
  - MUL: out_valid is visible WIDTH+1 cycles after the accept edge.
- Opcodes (result is modulo 2^WIDTH):
  - 0 PASSA: A.
  - 1 ADD: A+B. carry = bit WIDTH of the sum. overflow = signed overflow.
  - 2 SUB: A-B. carry = borrow, i.e. 1 iff A<B unsigned. overflow = signed overflow.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 PASSB (load).
  - 7 SHL: A<<n. carry = last bit shifted out; 0 if n=0.
  - 8 SHR: logical right shift, same carry rule as SHL.
  - 9 SRA: arithmetic right shift, same carry rule as SHL.
  - 10 MUL: unsigned shift-add, one multiplier bit per BUSY cycle. result = low WIDTH bits of the product. carry = 1 iff the high WIDTH bits are nonzero.
  - 11-15: result=0, illegal=1, zero=1, carry=0, overflow=0. Treated as single-cycle.
- Flags:
  - zero and negative always reflect the result.
  - overflow=0 for all ops except ADD/SUB.
  - carry=0 for logic/pass ops.
  - illegal=0 for legal ops.
- Shift amounts: inB bits above SHW-1 are ignored.
- Reset mid-operation: asserting rst_n low during BUSY or DONE aborts immediately (asynchronously) to reset values. No result is emitted after release.

Test Plan:
- WIDTH=8, ADD A=0xFF B=0x01 -> next cycle: out_valid=1, result=0x00, zero=1, carry=1, overflow=0, negative=0.
- SUB A=0x80 B=0x01 -> result=0x7F, overflow=1, carry=0. Then SUB A=0x00 B=0x01 -> result=0xFF, carry=1, negative=1.
- MUL A=0x0F B=0x11 -> in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept; result=0xFF, carry=0. Then MUL 0x10*0x10 -> result=0x00, zero=1, carry=1.
- Backpressure: issue XOR A=0xA5 B=0xFF and hold out_ready=0 for 3 cycles -> result=0x5A held stable, in_ready=0. Then drive out_ready=1 with in_valid=1 and SRA A=0x90 B=0x03 -> back-to-back accept; next result=0xF2, carry=0.
- Illegal opcode 12 with A=0x33 -> result=0x00, illegal=1, zero=1. Next legal op PASSA A=0x33 -> illegal=0, result=0x33.
- Pull rst_n low 4 cycles into a MUL -> out_valid=0, in_ready=1 and result=0 immediately. After release, no stale out_valid appears.
